// File: rtl/fetch_unit.sv
// Program counter / instruction register stage: issues imem reads on a req/ack
// handshake and latches the returned word. Optional FETCH_TIMEOUT_EN adds an ack timeout.
module fetch_unit #(
   parameter int unsigned DW      = 8,
   parameter int unsigned OPW     = 3,
   parameter int unsigned AW      = 5,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           memIns_en,
   input  logic           pc_en,
   input  logic           pc_load,
   input  logic           halt,
   output logic           imem_req,
   output logic [AW-1:0]  imem_addr,
   input  logic           imem_ack,
   input  logic [DW-1:0]  imem_rdata,
   output logic [OPW-1:0] opcode,
   output logic [AW-1:0]  operand,
   output logic [AW-1:0]  pc,
   output logic           ir_valid,
   output logic           busy,
   output logic           halted,
   output logic           fetch_err
);

   // Elaboration-time sanity on the field split and timeout depth.
   if (DW != OPW + AW) begin : g_bad_split
      $error("fetch_unit: DW must equal OPW+AW");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("fetch_unit: TIMEOUT must be at least 1");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   pc_q, pc_d;
   logic [DW-1:0]   ir_q, ir_d;
   logic            ir_valid_q, ir_valid_d;
   logic            req_q, req_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic            busy_q, busy_d;
   logic            halted_q, halted_d;
   logic            err_q, err_d;

`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   // State register and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pc_q       <= '0;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
         req_q      <= 1'b0;
         addr_q     <= '0;
         busy_q     <= 1'b0;
         halted_q   <= 1'b0;
         err_q      <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         cnt_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         busy_q     <= busy_d;
         halted_q   <= halted_d;
         err_q      <= err_d;
`ifdef FETCH_TIMEOUT_EN
         cnt_q      <= cnt_d;
`endif
      end
   end

   // Next-state logic; halt beats every other event, HALT is only left through rst.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      ir_valid_d = ir_valid_q;
      req_d      = req_q;
      addr_d     = addr_q;
      busy_d     = busy_q;
      halted_d   = halted_q;
      err_d      = err_q;
`ifdef FETCH_TIMEOUT_EN
      cnt_d      = cnt_q;
`endif

      if (state_q == S_HALT) begin
         state_d = S_HALT;
      end else if (halt) begin
         state_d  = S_HALT;
         req_d    = 1'b0;
         busy_d   = 1'b0;
         halted_d = 1'b1;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (memIns_en) begin
                  addr_d     = pc_q;
                  req_d      = 1'b1;
                  ir_valid_d = 1'b0;
                  busy_d     = 1'b1;
                  state_d    = S_REQ;
`ifdef FETCH_TIMEOUT_EN
                  cnt_d      = '0;
`endif
               end
               // The fetch above already captured the old PC.
               if (pc_load) begin
                  pc_d = ir_q[AW-1:0];
               end else if (pc_en) begin
                  pc_d = pc_q + AW'(1);
               end
            end
            S_REQ: begin
               if (imem_ack) begin
                  ir_d       = imem_rdata;
                  ir_valid_d = 1'b1;
                  req_d      = 1'b0;
                  busy_d     = 1'b0;
                  state_d    = S_IDLE;
               end
`ifdef FETCH_TIMEOUT_EN
               else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  // Expired: hand control an all-zero word, which decodes as HALT.
                  ir_d       = '0;
                  ir_valid_d = 1'b1;
                  err_d      = 1'b1;
                  req_d      = 1'b0;
                  busy_d     = 1'b0;
                  state_d    = S_IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
`endif
            end
            default: begin
               state_d = S_IDLE;
               req_d   = 1'b0;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   assign imem_req  = req_q;
   assign imem_addr = addr_q;
   assign opcode    = ir_q[DW-1 -: OPW];
   assign operand   = ir_q[AW-1:0];
   assign pc        = pc_q;
   assign ir_valid  = ir_valid_q;
   assign busy      = busy_q;
   assign halted    = halted_q;
`ifdef FETCH_TIMEOUT_EN
   assign fetch_err = err_q;
`else
   assign fetch_err = 1'b0;
   logic unused_err;
   assign unused_err = err_q;
`endif

endmodule
